alarm_bank: RTL and testbench

ALARM_BANK -- requirements
Module: alarm_bank

---
 rtl/alarm_pkg.sv | 51 +++++
 rtl/alarm_channel.sv | 132 +++++++++++++
 rtl/alarm_bank.sv | 106 ++++++++++
 tb/tb_alarm_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types, constants and helpers for the multi-channel alarm bank.
// Digit legality lives here so the top-level write decoder and any future user agree.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alm_state_t;

  localparam int SEC_PER_DAY = 86400;
  localparam int CNT_W       = 17;
  localparam int TMR_W       = 10;

  localparam logic [CNT_W-1:0] W_AH1 = 17'd36000;
  localparam logic [CNT_W-1:0] W_AH2 = 17'd3600;
  localparam logic [CNT_W-1:0] W_AM1 = 17'd600;
  localparam logic [CNT_W-1:0] W_AM2 = 17'd60;

  localparam logic [2:0] SEL_AM2 = 3'b010;
  localparam logic [2:0] SEL_AM1 = 3'b011;
  localparam logic [2:0] SEL_AH2 = 3'b100;
  localparam logic [2:0] SEL_AH1 = 3'b101;

  // A write is legal only if the resulting HH:MM stays a valid 24-hour time,
  // judged against the digit that is already stored in the other hour position.
  function automatic logic digit_write_ok(input logic [2:0] sel,
                                          input logic [3:0] val,
                                          input logic [3:0] cur_ah1,
                                          input logic [3:0] cur_ah2);
    logic ok;
    ok = 1'b0;
    case (sel)
      SEL_AM2: ok = (val <= 4'd9);
      SEL_AM1: ok = (val <= 4'd5);
      SEL_AH2: ok = (val <= 4'd9) && ((cur_ah1 != 4'd2) || (val <= 4'd3));
      SEL_AH1: ok = (val <= 4'd2) && ((val != 4'd2) || (cur_ah2 <= 4'd3));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [CNT_W-1:0] digits_to_sec(input logic [3:0] ah1,
                                                     input logic [3:0] ah2,
                                                     input logic [3:0] am1,
                                                     input logic [3:0] am2);
    return ({13'd0, ah1} * W_AH1) + ({13'd0, ah2} * W_AH2)
         + ({13'd0, am1} * W_AM1) + ({13'd0, am2} * W_AM2);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored HH:MM digits, registered target second, and the
// IDLE/RING/SNOOZE state machine with its shared ring/snooze second timer.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [3:0]       wr_val,
  input  logic [CNT_W-1:0] sec_cnt,
  input  logic             sec_tick,
  input  logic             alm_en,
  input  logic             snooze_edge,
  input  logic             stop_edge,
  output logic [3:0]       ah1,
  output logic [3:0]       ah2,
  output logic [3:0]       am1,
  output logic [3:0]       am2,
  output logic             ring,
  output logic             ring_nxt
);

  localparam logic [TMR_W-1:0] RING_LAST = TMR_W'(RING_SEC - 1);
  localparam logic [TMR_W-1:0] SNZ_LAST  = TMR_W'(SNOOZE_SEC - 1);
  localparam logic [2:0]       SNZ_MAX   = 3'(MAX_SNOOZE);

  alm_state_t       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       snz_cnt;
  logic [CNT_W-1:0] target;

  logic kill;
  logic match;
  logic ring_done;
  logic snz_done;
  logic enter_ring;
  logic leave_ring;

  // Disable, a write to this channel, or stop all outrank snooze, expiry and trigger.
  assign kill       = !alm_en || wr_en || stop_edge;
  assign match      = sec_tick && (sec_cnt == target) && (sec_cnt < CNT_W'(SEC_PER_DAY));
  assign ring_done  = sec_tick && (timer == RING_LAST);
  assign snz_done   = sec_tick && (timer == SNZ_LAST);
  assign enter_ring = !kill && (((state == ST_IDLE) && match) ||
                                ((state == ST_SNOOZE) && snz_done));
  assign leave_ring = (state == ST_RING) && (kill || snooze_edge || ring_done);
  // Exported so the top can register buzz on the same edge as ring.
  assign ring_nxt   = enter_ring || (ring && !leave_ring);

  // NOTE: every register below uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      ah1 <= 4'd0;
      ah2 <= 4'd0;
      am1 <= 4'd0;
      am2 <= 4'd0;
    end else if (wr_en) begin
      case (wr_sel)
        SEL_AH1: ah1 <= wr_val;
        SEL_AH2: ah2 <= wr_val;
        SEL_AM1: am1 <= wr_val;
        SEL_AM2: am2 <= wr_val;
        default: ;
      endcase
    end
  end

  // Target trails the digits by one cycle; the weighted sum stays off the match path.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      target <= '0;
    end else begin
      target <= digits_to_sec(ah1, ah2, am1, am2);
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      snz_cnt <= 3'd0;
      ring    <= 1'b0;
    end else begin
      ring <= ring_nxt;
      if (kill) begin
        state <= ST_IDLE;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (match) begin
              state   <= ST_RING;
              timer   <= '0;
              snz_cnt <= 3'd0;
            end
          end
          ST_RING: begin
            if (snooze_edge) begin
              timer <= '0;
              if (snz_cnt < SNZ_MAX) begin
                state   <= ST_SNOOZE;
                snz_cnt <= snz_cnt + 3'd1;
              end else begin
                state <= ST_IDLE;
              end
            end else if (ring_done) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (sec_tick) begin
              timer <= timer + TMR_W'(1);
            end
          end
          ST_SNOOZE: begin
            if (snz_done) begin
              state <= ST_RING;
              timer <= '0;
            end else if (sec_tick) begin
              timer <= timer + TMR_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALM alarm channels sharing one digit-entry port, snooze/stop
// buttons and a common buzzer output.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  localparam int CH_W      = (NUM_ALM > 1) ? $clog2(NUM_ALM) : 1
) (
  input  logic               clk_out,
  input  logic               rst,
  input  logic [CNT_W-1:0]   sec_cnt,
  input  logic               sec_tick,
  input  logic               load,
  input  logic               almin,
  input  logic [2:0]         select,
  input  logic [3:0]         loadin,
  input  logic [CH_W-1:0]    ch_sel,
  input  logic [NUM_ALM-1:0] alm_en,
  input  logic               snooze,
  input  logic               stop,
  output logic [3:0]         ah1,
  output logic [3:0]         ah2,
  output logic [3:0]         am1,
  output logic [3:0]         am2,
  output logic [NUM_ALM-1:0] ring,
  output logic               buzz
);

  logic               snooze_q;
  logic               stop_q;
  logic               snooze_edge;
  logic               stop_edge;
  logic               wr_ok;
  logic [NUM_ALM-1:0] wr_en;
  logic [NUM_ALM-1:0] ring_nxt;

  logic [3:0] ah1_a [NUM_ALM];
  logic [3:0] ah2_a [NUM_ALM];
  logic [3:0] am1_a [NUM_ALM];
  logic [3:0] am2_a [NUM_ALM];

  always_ff @(posedge clk_out) begin
    if (rst) begin
      snooze_q <= 1'b0;
      stop_q   <= 1'b0;
      buzz     <= 1'b0;
    end else begin
      snooze_q <= snooze;
      stop_q   <= stop;
      buzz     <= |ring_nxt;
    end
  end

  assign snooze_edge = snooze && !snooze_q;
  assign stop_edge   = stop && !stop_q;

  // Legality is judged on the readback digits, which belong to the addressed channel.
  assign wr_ok = almin && !load && digit_write_ok(select, loadin, ah1, ah2);

  // NOTE: defaults first so an unmatched ch_sel cannot infer a latch.
  always_comb begin
    ah1 = 4'd0;
    ah2 = 4'd0;
    am1 = 4'd0;
    am2 = 4'd0;
    for (int i = 0; i < NUM_ALM; i++) begin
      if (ch_sel == CH_W'(i)) begin
        ah1 = ah1_a[i];
        ah2 = ah2_a[i];
        am1 = am1_a[i];
        am2 = am2_a[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_ALM; g++) begin : g_ch
    assign wr_en[g] = wr_ok && (ch_sel == CH_W'(g));

    alarm_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_ch (
      .clk_out     (clk_out),
      .rst         (rst),
      .wr_en       (wr_en[g]),
      .wr_sel      (select),
      .wr_val      (loadin),
      .sec_cnt     (sec_cnt),
      .sec_tick    (sec_tick),
      .alm_en      (alm_en[g]),
      .snooze_edge (snooze_edge),
      .stop_edge   (stop_edge),
      .ah1         (ah1_a[g]),
      .ah2         (ah2_a[g]),
      .am1         (am1_a[g]),
      .am2         (am2_a[g]),
      .ring        (ring[g]),
      .ring_nxt    (ring_nxt[g])
    );
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: stimulus queues expected outputs with the
// cycle they are due; an independent monitor checks them on the falling edge.
module tb_alarm_bank;
  import alarm_pkg::*;

  localparam int NUM_ALM = 4;

  logic               clk_out = 1'b0;
  logic               rst;
  logic [CNT_W-1:0]   sec_cnt;
  logic               sec_tick;
  logic               load;
  logic               almin;
  logic [2:0]         select;
  logic [3:0]         loadin;
  logic [1:0]         ch_sel;
  logic [NUM_ALM-1:0] alm_en;
  logic               snooze;
  logic               stop;
  logic [3:0]         ah1, ah2, am1, am2;
  logic [NUM_ALM-1:0] ring;
  logic               buzz;

  always #5 clk_out = ~clk_out;

  alarm_bank #(
    .NUM_ALM    (NUM_ALM),
    .RING_SEC   (60),
    .SNOOZE_SEC (300),
    .MAX_SNOOZE (3)
  ) dut (
    .clk_out  (clk_out),
    .rst      (rst),
    .sec_cnt  (sec_cnt),
    .sec_tick (sec_tick),
    .load     (load),
    .almin    (almin),
    .select   (select),
    .loadin   (loadin),
    .ch_sel   (ch_sel),
    .alm_en   (alm_en),
    .snooze   (snooze),
    .stop     (stop),
    .ah1      (ah1),
    .ah2      (ah2),
    .am1      (am1),
    .am2      (am2),
    .ring     (ring),
    .buzz     (buzz)
  );

  typedef struct {
    int                 at;
    string              name;
    logic               is_dig;
    logic [NUM_ALM-1:0] ring;
    logic               buzz;
    logic [15:0]        dig;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk_out) cyc <= cyc + 1;

  // Monitor: pops every expectation whose due cycle has arrived.
  always @(negedge clk_out) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (e.at != cyc) begin
        n_fail++;
        $display("FAIL %s: checked late at cycle %0d, due %0d", e.name, cyc, e.at);
      end else if (e.is_dig) begin
        if ({ah1, ah2, am1, am2} !== e.dig) begin
          n_fail++;
          $display("FAIL %s: digits got %h expected %h", e.name, {ah1, ah2, am1, am2}, e.dig);
        end
      end else if (ring !== e.ring || buzz !== e.buzz) begin
        n_fail++;
        $display("FAIL %s: ring/buzz got %b/%b expected %b/%b", e.name, ring, buzz, e.ring, e.buzz);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: stimulus did not complete at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk_out);
    #1;
  endtask

  // Outputs due after the next rising edge, i.e. caused by the inputs set now.
  task automatic expect_out(input string name, input logic [NUM_ALM-1:0] r);
    exp_t e;
    e.at = cyc + 1; e.name = name; e.is_dig = 1'b0;
    e.ring = r; e.buzz = |r; e.dig = 16'h0;
    sb_q.push_back(e);
  endtask

  // Combinational readback, checked within the current cycle.
  task automatic expect_dig(input string name, input int ch, input logic [15:0] d);
    exp_t e;
    ch_sel = 2'(ch);
    e.at = cyc; e.name = name; e.is_dig = 1'b1;
    e.ring = '0; e.buzz = 1'b0; e.dig = d;
    sb_q.push_back(e);
    cycle();
  endtask

  task automatic wr(input int ch, input logic [2:0] sel, input logic [3:0] v);
    ch_sel = 2'(ch); select = sel; loadin = v; almin = 1'b1;
    cycle();
    almin = 1'b0;
  endtask

  task automatic tick(input int s);
    sec_cnt = 17'(s); sec_tick = 1'b1;
    cycle();
    sec_tick = 1'b0;
  endtask

  // n ticks; checks the ring state after tick n-1 and after tick n.
  task automatic run_ticks(input int n, input int s, input string name,
                           input logic [NUM_ALM-1:0] pre, input logic [NUM_ALM-1:0] post);
    for (int i = 0; i < n; i++) begin
      if (i == n - 2) expect_out({name, "_pre"}, pre);
      if (i == n - 1) expect_out(name, post);
      tick(s);
    end
  endtask

  initial begin
    rst = 1'b1; sec_cnt = '0; sec_tick = 1'b0; load = 1'b0; almin = 1'b0;
    select = 3'b000; loadin = 4'd0; ch_sel = 2'd0; alm_en = '0;
    snooze = 1'b0; stop = 1'b0;
    cycle();
    expect_out("reset_out", 4'b0000);
    cycle();
    rst = 1'b0;
    expect_dig("reset_dig", 0, 16'h0000);

    // Digit legality on channel 3 (disarmed).
    wr(3, SEL_AH1, 4'd2);
    wr(3, SEL_AH2, 4'd5);
    expect_dig("ah2_blocked", 3, 16'h2000);
    wr(3, SEL_AH1, 4'd1);
    wr(3, SEL_AH2, 4'd8);
    wr(3, SEL_AH1, 4'd2);
    expect_dig("ah1_blocked", 3, 16'h1800);
    wr(3, SEL_AM1, 4'd6);
    expect_dig("am1_blocked", 3, 16'h1800);
    wr(3, SEL_AM1, 4'd5);
    wr(3, SEL_AM2, 4'd9);
    wr(3, 3'b000, 4'd1);
    load = 1'b1;
    wr(3, SEL_AM2, 4'd3);
    load = 1'b0;
    expect_dig("am_load_chk", 3, 16'h1859);
    expect_dig("ch0_isolated", 0, 16'h0000);

    // Channel 0 at 07:30 rings for 60 ticks.
    wr(0, SEL_AH2, 4'd7);
    wr(0, SEL_AM1, 4'd3);
    alm_en = 4'b0001;
    cycle();
    expect_dig("ch0_0730", 0, 16'h0730);
    sec_cnt = 17'd27000;
    expect_out("no_tick_no_ring", 4'b0000);
    cycle();
    expect_out("pre_match", 4'b0000);
    tick(26999);
    expect_out("trig_ch0", 4'b0001);
    tick(27000);
    run_ticks(60, 27100, "ring_expire", 4'b0001, 4'b0000);

    // Channel 1 at 01:00: three snoozes then forced stop.
    wr(1, SEL_AH2, 4'd1);
    alm_en = 4'b0011;
    cycle();
    expect_out("trig_ch1", 4'b0010);
    tick(3600);
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1;
      expect_out("snooze", 4'b0000);
      cycle();
      snooze = 1'b0;
      run_ticks(300, 50000, "re_ring", 4'b0000, 4'b0010);
    end
    snooze = 1'b1;
    expect_out("snooze_limit", 4'b0000);
    cycle();
    snooze = 1'b0;
    run_ticks(300, 50000, "limit_idle", 4'b0000, 4'b0000);

    // Channels 0 and 2 at 00:00 across the day wrap, then stop.
    wr(0, SEL_AH2, 4'd0);
    wr(0, SEL_AM1, 4'd0);
    alm_en = 4'b0101;
    cycle();
    expect_out("pre_wrap", 4'b0000);
    tick(86399);
    expect_out("wrap_trig", 4'b0101);
    tick(0);
    stop = 1'b1;
    expect_out("stop_all", 4'b0000);
    cycle();
    stop = 1'b0;

    // Digit write and disarm each silence only their own channel.
    expect_out("retrig", 4'b0101);
    tick(0);
    expect_out("write_kills_ch2", 4'b0001);
    wr(2, SEL_AM2, 4'd1);
    cycle();
    expect_out("trig_ch2_0001", 4'b0101);
    tick(60);
    alm_en = 4'b0100;
    expect_out("disarm_ch0", 4'b0100);
    cycle();

    // Reset while ringing, then same-cycle snooze and stop.
    rst = 1'b1;
    expect_out("rst_mid_ring", 4'b0000);
    cycle();
    rst = 1'b0;
    expect_dig("rst_dig_ch2", 2, 16'h0000);
    expect_out("no_trig_after_rst", 4'b0000);
    tick(5);
    expect_out("trig_after_rst", 4'b0100);
    tick(0);
    snooze = 1'b1; stop = 1'b1;
    expect_out("snooze_stop", 4'b0000);
    cycle();
    snooze = 1'b0; stop = 1'b0;
    run_ticks(300, 1000, "stop_won", 4'b0000, 4'b0000);

    repeat (3) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
